mem_lsu: RTL and testbench

- Load/store initiator for the risc-16 CPU's data side; it is the master end of the single-port data RAM interface (addr, rw, mem_in, mem_out).
- Accepts one load or store request at a time from the datapath over a valid/ready handshake.
- Drives the RAM's combinational-read / posedge-write port and returns read data, or a fault flag, over a valid/ready response channel.
- Out-of-range accesses never reach the RAM; a saturating fault counter records them for debug.

---
 rtl/risc16_pkg.sv | 18 +
 rtl/mem_lsu.sv | 83 ++++++++
 tb/tb_mem_lsu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// Shared risc-16 definitions: data word type, RAM port encodings and LSU states.
package risc16_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned MEM_SIZE = 255;
  localparam logic        READ     = 1'b0;
  localparam logic        WRITE    = 1'b1;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mem_lsu.sv
// Load/store initiator for the risc-16 data RAM: one request at a time,
// a single RAM access cycle, then a held response with a fault flag.
//
// Handshakes: a transfer on req_* happens on a posedge where req_valid and
// req_ready are both 1; a transfer on resp_* happens on a posedge where
// resp_valid and resp_ready are both 1. Payloads are stable while valid is high.
module mem_lsu
  import risc16_pkg::*;
#(
  parameter int unsigned DATA_W   = risc16_pkg::DATA_W,
  parameter int unsigned ADDR_W   = risc16_pkg::ADDR_W,
  parameter int unsigned MEM_SIZE = risc16_pkg::MEM_SIZE,
  parameter logic        READ     = risc16_pkg::READ,
  parameter logic        WRITE    = risc16_pkg::WRITE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [15:0]       fault_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output lsu_state_t        dbg_state
);

  lsu_state_t state;
  logic       lat_we;
  logic       lat_fault;

  // ram_addr/ram_wdata double as the request latch, so they hold outside ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_fault   <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      resp_rdata  <= '0;
      resp_fault  <= 1'b0;
      fault_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata;
            lat_we    <= req_we;
            lat_fault <= (req_addr > ADDR_W'(MEM_SIZE));
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          resp_rdata <= (!lat_we && !lat_fault) ? ram_rdata : '0;
          resp_fault <= lat_fault;
          if (lat_fault && (fault_count != 16'hFFFF))
            fault_count <= fault_count + 16'd1;
          state <= RESP;
        end
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rst gates the write strobe directly so it drops before the reset edge settles.
  assign ram_rw     = ((state == ACCESS) && lat_we && !lat_fault && !rst) ? WRITE : READ;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural combinational-read /
// posedge-write data RAM as the slave.
module tb_mem_lsu;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_fault;
  logic [15:0] fault_count;
  logic [15:0] ram_addr;
  logic        ram_rw;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  lsu_state_t  dbg_state;

  logic [15:0] mem [0:255];
  int          n_chk = 0;
  int          n_bad = 0;
  int          wr_pulses = 0;
  int          cyc = 0;
  logic [15:0] exp_q [$];

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .fault_count(fault_count),
    .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset-independent RAM slave
  always #5 clk = ~clk;

  assign ram_rdata = (ram_addr <= 16'd255) ? mem[ram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rw == WRITE) begin
      wr_pulses <= wr_pulses + 1;
      if (ram_addr <= 16'd255) mem[ram_addr[7:0]] <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full request/response; hold = RESP cycles spent with resp_ready low.
  task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input logic exp_fault, input int hold);
    int   wr0;
    logic exp_wr;
    exp_wr = we && !exp_fault;
    wr0    = wr_pulses;
    @(negedge clk);
    check({tag, ".rdy_idle"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".acc_state"}, dbg_state, ACCESS);
    check({tag, ".acc_rw"}, ram_rw, exp_wr);
    check({tag, ".acc_addr"}, ram_addr, addr);
    check({tag, ".acc_rdy"}, req_ready, 0);
    check({tag, ".acc_vld"}, resp_valid, 0);
    if (exp_wr) check({tag, ".acc_wdata"}, ram_wdata, wdata);
    resp_ready = (hold == 0);
    @(negedge clk);
    check({tag, ".resp_vld"}, resp_valid, 1);
    check({tag, ".resp_data"}, resp_rdata, exp_rdata);
    check({tag, ".resp_fault"}, resp_fault, exp_fault);
    check({tag, ".resp_rw"}, ram_rw, READ);
    if (hold > 0) begin
      repeat (hold - 1) begin
        @(negedge clk);
        check({tag, ".hold_vld"}, resp_valid, 1);
        check({tag, ".hold_data"}, resp_rdata, exp_rdata);
        check({tag, ".hold_rdy"}, req_ready, 0);
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, ".done_vld"}, resp_valid, 0);
    check({tag, ".done_rdy"}, req_ready, 1);
    check({tag, ".wr_pulses"}, wr_pulses - wr0, exp_wr ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ai, ri, last_cyc;
    logic [15:0] b2b_addr [4];
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 10);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.state", dbg_state, IDLE);
    check("rst.rdy", req_ready, 1);
    check("rst.vld", resp_valid, 0);
    check("rst.rdata", resp_rdata, 0);
    check("rst.fault", resp_fault, 0);
    check("rst.fcnt", fault_count, 0);
    check("rst.raddr", ram_addr, 0);
    check("rst.rw", ram_rw, READ);
    rst = 1'b0;

    // store then load back
    do_req("st20", 1'b1, 16'h0020, 16'd42, 16'd0, 1'b0, 0);
    do_req("ld20", 1'b0, 16'h0020, 16'h0, 16'd42, 1'b0, 0);
    do_req("ld01", 1'b0, 16'h0001, 16'h0, 16'd10, 1'b0, 0);

    // out-of-range store, then the last valid address
    do_req("st100", 1'b1, 16'h0100, 16'hBEEF, 16'd0, 1'b1, 0);
    check("fcnt1", fault_count, 1);
    do_req("ldff", 1'b0, 16'h00FF, 16'h0, 16'd2550, 1'b0, 0);
    check("fcnt1b", fault_count, 1);
    do_req("ldffff", 1'b0, 16'hFFFF, 16'h0, 16'd0, 1'b1, 0);
    check("fcnt2", fault_count, 2);

    // backpressure
    do_req("ld0f_hold", 1'b0, 16'h000F, 16'h0, 16'd150, 1'b0, 5);

    // reset in the middle of a store's ACCESS cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0030; req_wdata = 16'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstacc.rw_before", ram_rw, WRITE);
    #2 rst = 1'b1;
    #1;
    check("rstacc.rw", ram_rw, READ);
    check("rstacc.state", dbg_state, IDLE);
    check("rstacc.rdy", req_ready, 1);
    check("rstacc.vld", resp_valid, 0);
    check("rstacc.fcnt", fault_count, 0);
    check("rstacc.raddr", ram_addr, 0);
    check("rstacc.wdata", ram_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    do_req("ld30", 1'b0, 16'h0030, 16'h0, 16'd480, 1'b0, 0);

    // back-to-back loads, req_valid and resp_ready held high
    b2b_addr[0] = 16'h0000; b2b_addr[1] = 16'h0001;
    b2b_addr[2] = 16'h000F; b2b_addr[3] = 16'h0010;
    exp_q.push_back(16'd0);   exp_q.push_back(16'd10);
    exp_q.push_back(16'd150); exp_q.push_back(16'd160);
    ai = 0; ri = 0; last_cyc = 0;
    resp_ready = 1'b1; req_we = 1'b0;
    for (int c = 0; c < 30 && ri < 4; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        check("b2b.data", resp_rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX);
        if (ri > 0) check("b2b.gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        ri++;
      end
      if (req_ready) begin
        if (ai < 4) begin
          req_valid = 1'b1;
          req_addr  = b2b_addr[ai];
          ai++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b.count", ri, 4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
